// File: rtl/median_ncw_pkg.sv
// Shared definitions for the median_filter_ncw 3x3 filter: mode encodings,
// pipeline latency and the three-input median helper.
package median_ncw_pkg;

  typedef enum logic [1:0] {
    MODE_MEDIAN = 2'd0,
    MODE_MIN    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  // Input pixel accepted -> po_flag, in sclk cycles
  localparam int MF_LAT = 5;

  // Operand width of med3; callers zero-extend DW-wide channels into it
  localparam int MED3_W = 64;

  function automatic logic [MED3_W-1:0] med3(input logic [MED3_W-1:0] a,
                                             input logic [MED3_W-1:0] b,
                                             input logic [MED3_W-1:0] c);
    logic [MED3_W-1:0] hi, lo;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    if (c >= hi)      return hi;
    else if (c <= lo) return lo;
    else              return c;
  endfunction

endpackage

// File: rtl/median_window_3x3.sv
// Two-line window generator for the 3x3 filter. Tracks raster position,
// keeps the two previous lines in RAM and shifts a 3x3 window of full
// pixels (all channels). win[r][c]: r=0 is the oldest line, c=2 the newest
// column, so win[1][1] is the window centre (row-1, col-1).
module median_window_3x3 #(
  parameter int DW      = 8,
  parameter int CH      = 3,
  parameter int COL_NUM = 1024,
  parameter int ROW_NUM = 768
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic [CH*DW-1:0]             pi_data,
  input  logic                         pi_flag,
  input  logic                         sync_clr,
  output logic [2:0][2:0][CH*DW-1:0]   win,
  output logic                         win_vld,
  output logic                         win_last,
  output logic                         first_px
);

  localparam int PW = CH*DW;
  localparam int CW = $clog2(COL_NUM);
  localparam int RW = $clog2(ROW_NUM);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic [PW-1:0] lb0_mem [COL_NUM];  // line row-1
  logic [PW-1:0] lb1_mem [COL_NUM];  // line row-2
  logic [PW-1:0] up1, up2;
  logic [2:0][2:0][PW-1:0] win_q, win_d;
  logic win_vld_q, win_vld_d, win_last_q, win_last_d;

  // Position bookkeeping; sync_clr makes the current pixel (0,0) and beats any wrap
  always_comb begin
    col_eff = sync_clr ? '0 : col_q;
    row_eff = sync_clr ? '0 : row_q;
    col_d   = col_eff;
    row_d   = row_eff;
    if (pi_flag) begin
      if (col_eff == CW'(COL_NUM-1)) begin
        col_d = '0;
        row_d = (row_eff == RW'(ROW_NUM-1)) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
      end
    end
    win_vld_d  = pi_flag && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
    win_last_d = win_vld_d && (row_eff == RW'(ROW_NUM-1)) && (col_eff == CW'(COL_NUM-1));
    first_px   = pi_flag && (row_eff == '0) && (col_eff == '0);
  end

  // New window column: two lines from RAM plus the incoming pixel
  always_comb begin
    up1   = lb0_mem[col_eff];
    up2   = lb1_mem[col_eff];
    win_d = win_q;
    if (pi_flag) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = up2;
      win_d[1][2] = up1;
      win_d[2][2] = pi_data;
    end
  end

  // Counters, window and valid registers
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      win_vld_q  <= win_vld_d;
      win_last_q <= win_last_d;
    end
  end

  // Line RAMs: contents are don't-care after reset, so no reset here
  always_ff @(posedge sclk) begin
    if (pi_flag) begin
      lb1_mem[col_eff] <= up1;
      lb0_mem[col_eff] <= pi_data;
    end
  end

  assign win      = win_q;
  assign win_vld  = win_vld_q;
  assign win_last = win_last_q;

endmodule

// File: rtl/median_filter_ncw.sv
// CH-channel 3x3 median/min/max/bypass filter with built-in line buffers.
// Stages: S1 window, S2 row sort, S3 column stage, S4 mode mux, S5 output.
// Optional build macro MEDIAN_FILTER_NCW_IMPULSE_EN: in median mode only pixels
// further than THRESH from the local median are replaced by it.
module median_filter_ncw
  import median_ncw_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CH      = 3,
  parameter int COL_NUM = 1024,
  parameter int ROW_NUM = 768,
  parameter int THRESH  = 80
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [CH*DW-1:0] pi_data,
  input  logic             pi_flag,
  input  logic             sync_clr,
  input  logic [1:0]       mode,
  output logic [CH*DW-1:0] po_data,
  output logic             po_flag,
  output logic             frame_done
);

`ifdef MEDIAN_FILTER_NCW_IMPULSE_EN
  localparam bit IMPULSE_EN = 1'b1;
`else
  localparam bit IMPULSE_EN = 1'b0;
`endif

  // Valid stages after the window register: S2, S3, S4, S5
  localparam int STAGES = MF_LAT - 2;

  function automatic logic [DW-1:0] mx3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c);
    logic [DW-1:0] t;
    t = (a > b) ? a : b;
    return (t > c) ? t : c;
  endfunction

  function automatic logic [DW-1:0] mn3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c);
    logic [DW-1:0] t;
    t = (a < b) ? a : b;
    return (t < c) ? t : c;
  endfunction

  function automatic logic [DW-1:0] m3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [DW-1:0] c);
    return DW'(med3(MED3_W'(a), MED3_W'(b), MED3_W'(c)));
  endfunction

  logic [2:0][2:0][CH*DW-1:0] win;
  logic win_vld, win_last, first_px;

  mode_e mode_q, mode_d;
  mode_e mode_pipe_q [3];
  mode_e mode_pipe_d [3];
  logic [STAGES:0] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
  logic [CH-1:0][DW-1:0] s4_d, s4_q, po_data_q, po_data_d;

  median_window_3x3 #(
    .DW(DW), .CH(CH), .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM)
  ) u_win (
    .sclk     (sclk),
    .rst      (rst),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .sync_clr (sync_clr),
    .win      (win),
    .win_vld  (win_vld),
    .win_last (win_last),
    .first_px (first_px)
  );

  // Frame mode latched at (0,0); a per-stage copy rides along with the data
  // so the tail of one frame is unaffected by the next frame's mode
  always_comb begin
    mode_d         = first_px ? mode_e'(mode) : mode_q;
    mode_pipe_d[0] = mode_q;
    mode_pipe_d[1] = mode_pipe_q[0];
    mode_pipe_d[2] = mode_pipe_q[1];
    vld_pipe_d     = sync_clr ? '0 : {vld_pipe_q[STAGES-1:0], win_vld};
    last_pipe_d    = sync_clr ? '0 : {last_pipe_q[STAGES-1:0], win_last};
    po_data_d      = vld_pipe_q[STAGES-1] ? s4_q : po_data_q;
  end

  // Control pipeline, S4 result and S5 output register
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_MEDIAN;
      for (int i = 0; i < 3; i++) mode_pipe_q[i] <= MODE_MEDIAN;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      s4_q        <= '0;
      po_data_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      for (int i = 0; i < 3; i++) mode_pipe_q[i] <= mode_pipe_d[i];
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      s4_q        <= s4_d;
      po_data_q   <= po_data_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DW-1:0] rmax_d [3];
    logic [DW-1:0] rmid_d [3];
    logic [DW-1:0] rmin_d [3];
    logic [DW-1:0] rmax_q [3];
    logic [DW-1:0] rmid_q [3];
    logic [DW-1:0] rmin_q [3];
    logic [DW-1:0] ctr2_d, ctr2_q, ctr3_d, ctr3_q;
    logic [DW-1:0] mnmx_d, mdmd_d, mxmn_d, gmin_d, gmax_d;
    logic [DW-1:0] mnmx_q, mdmd_q, mxmn_q, gmin_q, gmax_q;
    logic [DW-1:0] med, diff, res;

    // S2: sort each window row into max/mid/min
    always_comb begin
      for (int r = 0; r < 3; r++) begin
        rmax_d[r] = mx3(win[r][0][g*DW +: DW], win[r][1][g*DW +: DW], win[r][2][g*DW +: DW]);
        rmid_d[r] = m3 (win[r][0][g*DW +: DW], win[r][1][g*DW +: DW], win[r][2][g*DW +: DW]);
        rmin_d[r] = mn3(win[r][0][g*DW +: DW], win[r][1][g*DW +: DW], win[r][2][g*DW +: DW]);
      end
      ctr2_d = win[1][1][g*DW +: DW];
    end

    // S3: column stage; min-of-max/med-of-mid/max-of-min bracket the 9-point median
    always_comb begin
      mnmx_d = mn3(rmax_q[0], rmax_q[1], rmax_q[2]);
      mdmd_d = m3 (rmid_q[0], rmid_q[1], rmid_q[2]);
      mxmn_d = mx3(rmin_q[0], rmin_q[1], rmin_q[2]);
      gmin_d = mn3(rmin_q[0], rmin_q[1], rmin_q[2]);
      gmax_d = mx3(rmax_q[0], rmax_q[1], rmax_q[2]);
      ctr3_d = ctr2_q;
    end

    // S4: final median and mode select (impulse compare folded in here)
    always_comb begin
      med  = m3(mnmx_q, mdmd_q, mxmn_q);
      diff = (ctr3_q > med) ? ctr3_q - med : med - ctr3_q;
      case (mode_pipe_q[2])
        MODE_MIN:    res = gmin_q;
        MODE_MAX:    res = gmax_q;
        MODE_BYPASS: res = ctr3_q;
        default:     res = (!IMPULSE_EN || (MED3_W'(diff) > MED3_W'(THRESH))) ? med : ctr3_q;
      endcase
    end

    assign s4_d[g] = res;

    // S2/S3 data registers; they advance every cycle, valid travels alongside
    always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
        for (int r = 0; r < 3; r++) begin
          rmax_q[r] <= '0;
          rmid_q[r] <= '0;
          rmin_q[r] <= '0;
        end
        ctr2_q <= '0;
        ctr3_q <= '0;
        mnmx_q <= '0;
        mdmd_q <= '0;
        mxmn_q <= '0;
        gmin_q <= '0;
        gmax_q <= '0;
      end else begin
        for (int r = 0; r < 3; r++) begin
          rmax_q[r] <= rmax_d[r];
          rmid_q[r] <= rmid_d[r];
          rmin_q[r] <= rmin_d[r];
        end
        ctr2_q <= ctr2_d;
        ctr3_q <= ctr3_d;
        mnmx_q <= mnmx_d;
        mdmd_q <= mdmd_d;
        mxmn_q <= mxmn_d;
        gmin_q <= gmin_d;
        gmax_q <= gmax_d;
      end
    end
  end

  assign po_data    = po_data_q;
  assign po_flag    = vld_pipe_q[STAGES];
  assign frame_done = last_pipe_q[STAGES];

endmodule
